// File: rtl/cache_bus_pkg.sv
// Shared types and geometry for the bus-1 cache frontend.
package cache_bus_pkg;

    localparam int TAG_SET_W    = 14;
    localparam int OFFSET_W     = 4;
    localparam int CACHE_ADDR_W = TAG_SET_W + OFFSET_W;
    localparam int DATA1_W      = 16;
    localparam int CTR1_W       = 3;
    localparam int CMD_W        = 3;
    localparam int WORD_W       = 32;

    typedef enum logic [CMD_W-1:0] {
        C1_NOP             = 3'd0,
        C1_READ8           = 3'd1,
        C1_READ16          = 3'd2,
        C1_READ32          = 3'd3,
        C1_INVALIDATE_LINE = 3'd4,
        C1_WRITE8          = 3'd5,
        C1_WRITE16         = 3'd6,
        C1_WRITE32         = 3'd7
    } c1_cmd_e;

    // The response code shares its encoding with WRITE32, so it cannot be
    // a separate enum member.
    localparam logic [CMD_W-1:0] C1_RESPONSE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR2,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP0,
        ST_RESP1,
        ST_TURN
    } fe_state_e;

    // Write payload as seen by the core; reads and invalidates carry none.
    function automatic logic [WORD_W-1:0] pack_wdata(input logic [CMD_W-1:0] cmd,
                                                     input logic [15:0] w0,
                                                     input logic [15:0] w1);
        case (cmd)
            C1_WRITE8:  return {24'h0, w0[7:0]};
            C1_WRITE16: return {16'h0, w0};
            C1_WRITE32: return {w1, w0};
            default:    return '0;
        endcase
    endfunction

    // Data placed on D1 during the first response cycle.
    function automatic logic [15:0] resp_lo(input logic [CMD_W-1:0] cmd,
                                            input logic [WORD_W-1:0] rd);
        case (cmd)
            C1_READ8:             return {8'h0, rd[7:0]};
            C1_READ16, C1_READ32: return rd[15:0];
            default:              return '0;
        endcase
    endfunction

endpackage

// File: rtl/bus1_tristate_drv.sv
// Output-enable driver for one shared bus-1 signal group; releases to 'z.
module bus1_tristate_drv #(
    parameter int W = 16
) (
    input  logic         en,
    input  logic [W-1:0] data,
    inout  wire  [W-1:0] pad
);

    assign pad = en ? data : {W{1'bz}};

endmodule

// File: rtl/cache_bus1_frontend.sv
// Cache-side slave for CPU bus 1: captures the two-phase CPU command,
// issues one request to the cache core and returns the response on C1/D1.
module cache_bus1_frontend
    import cache_bus_pkg::*;
#(
    parameter int ADDR1_BUS_SIZE    = 14,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_ADDR_SIZE   = 18,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [ADDR1_BUS_SIZE-1:0]  A1,
    inout  wire  [DATA1_BUS_SIZE-1:0]  D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]   C1,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [CMD_W-1:0]           req_cmd,
    output logic [CACHE_ADDR_SIZE-1:0] req_addr,
    output logic [WORD_W-1:0]          req_wdata,
    input  logic                       resp_valid,
    input  logic [WORD_W-1:0]          resp_rdata,
    output logic                       err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    fe_state_e                 state;
    logic [DATA1_BUS_SIZE-1:0] word0;
    logic [WORD_W-1:0]         rdata;
    logic [CNT_W-1:0]          wait_cnt;
    logic [CMD_W-1:0]          c1_in;
    logic                      bus_en;
    logic [DATA1_BUS_SIZE-1:0] d1_out;

    assign c1_in = C1[CMD_W-1:0];

    // Request capture, core handshake, wait/timeout and response sequencing.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            req_valid   <= 1'b0;
            req_cmd     <= '0;
            req_addr    <= '0;
            req_wdata   <= '0;
            err_timeout <= 1'b0;
            word0       <= '0;
            rdata       <= '0;
            wait_cnt    <= '0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                // An undriven (z/x) C1 compares unknown and is ignored like NOP.
                ST_IDLE: if (c1_in != C1_NOP) begin
                    req_cmd                                     <= c1_in;
                    req_addr[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE] <= A1;
                    word0                                       <= D1;
                    state                                       <= ST_ADDR2;
                end
                // Phase 2 carries the offset and, for WRITE32, the high half.
                ST_ADDR2: begin
                    req_addr[CACHE_OFFSET_SIZE-1:0] <= A1[CACHE_OFFSET_SIZE-1:0];
                    req_wdata <= pack_wdata(req_cmd, word0, D1);
                    req_valid <= 1'b1;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: if (req_ready) begin
                    req_valid <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT;
                end
                // A response arriving on the timeout cycle takes priority.
                ST_WAIT: begin
                    if (resp_valid) begin
                        rdata <= resp_rdata;
                        state <= ST_RESP0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rdata       <= '0;
                        err_timeout <= 1'b1;
                        state       <= ST_RESP0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP0: state <= (req_cmd == C1_READ32) ? ST_RESP1 : ST_TURN;
                ST_RESP1: state <= ST_TURN;
                ST_TURN:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Bus is owned only in the response states; everything else releases it.
    always_comb begin
        bus_en = 1'b0;
        d1_out = '0;
        case (state)
            ST_RESP0: begin
                bus_en = 1'b1;
                d1_out = resp_lo(req_cmd, rdata);
            end
            ST_RESP1: begin
                bus_en = 1'b1;
                d1_out = rdata[31:16];
            end
            default: ;
        endcase
    end

    bus1_tristate_drv #(.W(DATA1_BUS_SIZE)) u_d1_drv (
        .en   (bus_en),
        .data (d1_out),
        .pad  (D1)
    );

    bus1_tristate_drv #(.W(CTR1_BUS_SIZE)) u_c1_drv (
        .en   (bus_en),
        .data (CTR1_BUS_SIZE'(C1_RESPONSE)),
        .pad  (C1)
    );

endmodule

// File: tb/tb_cache_bus1_frontend.sv
// Directed bench for cache_bus1_frontend. Released buses are pulled
// (D1 high, C1 low) so a released bus is visible as a known value.
module tb_cache_bus1_frontend;
    import cache_bus_pkg::*;

    localparam int TO = 255;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [13:0] A1 = '0;
    tri1  [15:0] D1;
    tri0  [2:0]  C1;
    logic        cpu_en = 1'b0;
    logic [15:0] cpu_d = '0;
    logic [2:0]  cpu_c = '0;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic        req_valid, err_timeout;
    logic [2:0]  req_cmd;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    int          n_pass = 0;
    int          n_total = 0;

    assign D1 = cpu_en ? cpu_d : 16'hzzzz;
    assign C1 = cpu_en ? cpu_c : 3'bzzz;

    always #5 CLK = ~CLK;

    cache_bus1_frontend dut (
        .CLK(CLK), .RESET_N(RESET_N), .A1(A1), .D1(D1), .C1(C1),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .err_timeout(err_timeout)
    );

    // CPU two-phase command; returns 1ns after the edge that enters ISSUE.
    task automatic cpu_issue(input logic [2:0] cmd, input logic [13:0] ahi, input logic [15:0] d0,
                             input logic [13:0] alo, input logic [15:0] d1v);
        @(posedge CLK); #1;
        cpu_en = 1'b1; cpu_c = cmd; A1 = ahi; cpu_d = d0;
        @(posedge CLK); #1;
        cpu_c = 3'd0; A1 = alo; cpu_d = d1v;
        @(posedge CLK); #1;
        cpu_en = 1'b0;
    endtask

    // Core answer sampled lat edges after the accept edge; call 1ns after accept.
    task automatic core_resp(input int lat, input logic [31:0] data);
        if (lat > 1) begin
            repeat (lat - 1) @(posedge CLK);
            #1;
        end
        resp_valid = 1'b1; resp_rdata = data;
        @(posedge CLK); #1;
        resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_total++; if (dut.state !== ST_IDLE) $display("FAIL rst_state got=%0d exp=%0d", dut.state, ST_IDLE); else n_pass++;
        n_total++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid got=%b exp=0", req_valid); else n_pass++;
        n_total++; if (req_cmd !== 3'd0) $display("FAIL rst_req_cmd got=%h exp=0", req_cmd); else n_pass++;
        n_total++; if (req_addr !== 18'h0) $display("FAIL rst_req_addr got=%h exp=0", req_addr); else n_pass++;
        n_total++; if (req_wdata !== 32'h0) $display("FAIL rst_req_wdata got=%h exp=0", req_wdata); else n_pass++;
        n_total++; if (err_timeout !== 1'b0) $display("FAIL rst_err got=%b exp=0", err_timeout); else n_pass++;
        n_total++; if (C1 !== 3'b000 || D1 !== 16'hFFFF) $display("FAIL rst_bus_release got C1=%h D1=%h exp C1=0 D1=ffff", C1, D1); else n_pass++;
        RESET_N = 1'b1;
        @(negedge CLK);
        n_total++; if (req_valid !== 1'b0) $display("FAIL idle_quiet got=%b exp=0", req_valid); else n_pass++;
    endtask

    task automatic test_read8();
        cpu_issue(3'd1, 14'h0001, 16'h0000, 14'h0002, 16'h0000);
        req_ready = 1'b1;
        @(negedge CLK);
        n_total++; if (req_valid !== 1'b1) $display("FAIL r8_valid got=%b exp=1", req_valid); else n_pass++;
        n_total++; if (req_cmd !== 3'd1) $display("FAIL r8_cmd got=%h exp=1", req_cmd); else n_pass++;
        n_total++; if (req_addr !== 18'h00012) $display("FAIL r8_addr got=%h exp=00012", req_addr); else n_pass++;
        n_total++; if (req_wdata !== 32'h0) $display("FAIL r8_wdata got=%h exp=0", req_wdata); else n_pass++;
        n_total++; if (C1 !== 3'b000) $display("FAIL r8_issue_bus got=%h exp=0", C1); else n_pass++;
        @(posedge CLK); #1; req_ready = 1'b0;
        core_resp(4, 32'h000000A5);
        @(negedge CLK);
        n_total++; if (C1 !== 3'd7 || D1 !== 16'h00A5) $display("FAIL r8_resp got C1=%h D1=%h exp C1=7 D1=00a5", C1, D1); else n_pass++;
        @(negedge CLK);
        n_total++; if (C1 !== 3'b000 || D1 !== 16'hFFFF || dut.state !== ST_TURN)
            $display("FAIL r8_turn got C1=%h D1=%h st=%0d exp C1=0 D1=ffff st=%0d", C1, D1, dut.state, ST_TURN); else n_pass++;
    endtask

    task automatic test_read32();
        cpu_issue(3'd3, 14'h0F00, 16'h0000, 14'h0000, 16'h0000);
        req_ready = 1'b1;
        @(negedge CLK);
        n_total++; if (req_addr !== 18'h0F000) $display("FAIL r32_addr got=%h exp=0f000", req_addr); else n_pass++;
        @(posedge CLK); #1; req_ready = 1'b0;
        core_resp(1, 32'hDEADBEEF);
        @(negedge CLK);
        n_total++; if (C1 !== 3'd7 || D1 !== 16'hBEEF) $display("FAIL r32_resp0 got C1=%h D1=%h exp C1=7 D1=beef", C1, D1); else n_pass++;
        @(negedge CLK);
        n_total++; if (C1 !== 3'd7 || D1 !== 16'hDEAD) $display("FAIL r32_resp1 got C1=%h D1=%h exp C1=7 D1=dead", C1, D1); else n_pass++;
        @(negedge CLK);
        n_total++; if (C1 !== 3'b000 || D1 !== 16'hFFFF) $display("FAIL r32_turn got C1=%h D1=%h exp C1=0 D1=ffff", C1, D1); else n_pass++;
    endtask

    task automatic test_write32();
        cpu_issue(3'd7, 14'h0100, 16'h5678, 14'h0004, 16'h1234);
        req_ready = 1'b1;
        @(negedge CLK);
        n_total++; if (req_cmd !== 3'd7) $display("FAIL w32_cmd got=%h exp=7", req_cmd); else n_pass++;
        n_total++; if (req_addr !== 18'h01004) $display("FAIL w32_addr got=%h exp=01004", req_addr); else n_pass++;
        n_total++; if (req_wdata !== 32'h12345678) $display("FAIL w32_wdata got=%h exp=12345678", req_wdata); else n_pass++;
        @(posedge CLK); #1; req_ready = 1'b0;
        core_resp(2, 32'hFFFFFFFF);
        @(negedge CLK);
        n_total++; if (C1 !== 3'd7 || D1 !== 16'h0000) $display("FAIL w32_resp got C1=%h D1=%h exp C1=7 D1=0000", C1, D1); else n_pass++;
        @(negedge CLK);
        n_total++; if (C1 !== 3'b000 || dut.state !== ST_TURN) $display("FAIL w32_turn got C1=%h st=%0d exp C1=0 st=%0d", C1, dut.state, ST_TURN); else n_pass++;
    endtask

    task automatic test_stall();
        cpu_issue(3'd5, 14'h2AAA, 16'hABCD, 14'h0009, 16'h0000);
        req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_total++;
            if ({req_valid, req_cmd, req_addr, req_wdata} !== {1'b1, 3'd5, 18'h2AAA9, 32'h000000CD} || C1 !== 3'b000 || D1 !== 16'hFFFF)
                $display("FAIL stall_hold cyc=%0d got v=%b c=%h a=%h w=%h C1=%h D1=%h exp v=1 c=5 a=2aaa9 w=000000cd C1=0 D1=ffff",
                         i, req_valid, req_cmd, req_addr, req_wdata, C1, D1);
            else n_pass++;
        end
        req_ready = 1'b1;
        @(posedge CLK); #1; req_ready = 1'b0;
        @(negedge CLK);
        n_total++; if (req_valid !== 1'b0 || C1 !== 3'b000) $display("FAIL stall_wait got v=%b C1=%h exp v=0 C1=0", req_valid, C1); else n_pass++;
        core_resp(1, 32'h0);
        @(negedge CLK);
        n_total++; if (C1 !== 3'd7) $display("FAIL stall_resp got C1=%h exp=7", C1); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        cpu_issue(3'd2, 14'h0321, 16'h0000, 14'h0007, 16'h0000);
        req_ready = 1'b1;
        @(posedge CLK); #1; req_ready = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (i < TO) early = early | err_timeout | (C1 !== 3'b000);
        end
        n_total++; if (early !== 1'b0) $display("FAIL to_early got=%b exp=0", early); else n_pass++;
        n_total++; if (err_timeout !== 1'b1) $display("FAIL to_pulse got=%b exp=1", err_timeout); else n_pass++;
        n_total++; if (C1 !== 3'd7 || D1 !== 16'h0000) $display("FAIL to_resp got C1=%h D1=%h exp C1=7 D1=0000", C1, D1); else n_pass++;
        @(negedge CLK);
        n_total++; if (err_timeout !== 1'b0 || dut.state !== ST_TURN) $display("FAIL to_one_cycle got e=%b st=%0d exp e=0 st=%0d", err_timeout, dut.state, ST_TURN); else n_pass++;
        @(negedge CLK);
        n_total++; if (dut.state !== ST_IDLE) $display("FAIL to_idle got=%0d exp=%0d", dut.state, ST_IDLE); else n_pass++;
    endtask

    task automatic test_tie();
        cpu_issue(3'd1, 14'h0055, 16'h0000, 14'h0003, 16'h0000);
        req_ready = 1'b1;
        @(posedge CLK); #1; req_ready = 1'b0;
        for (int i = 1; i < TO; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        resp_valid = 1'b1; resp_rdata = 32'h1234565A;
        @(posedge CLK); #1; resp_valid = 1'b0;
        @(negedge CLK);
        n_total++; if (err_timeout !== 1'b0) $display("FAIL tie_no_err got=%b exp=0", err_timeout); else n_pass++;
        n_total++; if (C1 !== 3'd7 || D1 !== 16'h005A) $display("FAIL tie_resp got C1=%h D1=%h exp C1=7 D1=005a", C1, D1); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        // Reset while waiting on the core, then a stale response arrives.
        cpu_issue(3'd1, 14'h0010, 16'h0000, 14'h0001, 16'h0000);
        req_ready = 1'b1;
        @(posedge CLK); #1; req_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1; RESET_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        n_total++; if (dut.state !== ST_IDLE || req_valid !== 1'b0 || C1 !== 3'b000 || D1 !== 16'hFFFF)
            $display("FAIL rst_wait got st=%0d v=%b C1=%h D1=%h exp st=%0d v=0 C1=0 D1=ffff", dut.state, req_valid, C1, D1, ST_IDLE); else n_pass++;
        RESET_N = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h00000077;
        @(posedge CLK);
        @(negedge CLK); resp_valid = 1'b0;
        n_total++; if (dut.state !== ST_IDLE || C1 !== 3'b000 || D1 !== 16'hFFFF)
            $display("FAIL rst_discard got st=%0d C1=%h D1=%h exp st=%0d C1=0 D1=ffff", dut.state, C1, D1, ST_IDLE); else n_pass++;
        // Reset during the second READ32 response beat.
        cpu_issue(3'd3, 14'h0200, 16'h0000, 14'h0000, 16'h0000);
        req_ready = 1'b1;
        @(posedge CLK); #1; req_ready = 1'b0;
        core_resp(1, 32'h01234567);
        @(posedge CLK);
        @(negedge CLK);
        n_total++; if (C1 !== 3'd7 || D1 !== 16'h0123) $display("FAIL rst_r1_pre got C1=%h D1=%h exp C1=7 D1=0123", C1, D1); else n_pass++;
        RESET_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        n_total++; if (dut.state !== ST_IDLE || req_valid !== 1'b0 || C1 !== 3'b000 || D1 !== 16'hFFFF)
            $display("FAIL rst_resp1 got st=%0d v=%b C1=%h D1=%h exp st=%0d v=0 C1=0 D1=ffff", dut.state, req_valid, C1, D1, ST_IDLE); else n_pass++;
        RESET_N = 1'b1;
        // A normal READ16 after recovery.
        cpu_issue(3'd2, 14'h1357, 16'h0000, 14'h000A, 16'h0000);
        req_ready = 1'b1;
        @(negedge CLK);
        n_total++; if (req_cmd !== 3'd2 || req_addr !== 18'h1357A) $display("FAIL r16_req got c=%h a=%h exp c=2 a=1357a", req_cmd, req_addr); else n_pass++;
        @(posedge CLK); #1; req_ready = 1'b0;
        core_resp(3, 32'h1234CAFE);
        @(negedge CLK);
        n_total++; if (C1 !== 3'd7 || D1 !== 16'hCAFE) $display("FAIL r16_resp got C1=%h D1=%h exp C1=7 D1=cafe", C1, D1); else n_pass++;
        @(negedge CLK);
        n_total++; if (C1 !== 3'b000 || dut.state !== ST_TURN) $display("FAIL r16_turn got C1=%h st=%0d exp C1=0 st=%0d", C1, dut.state, ST_TURN); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read8();
        test_read32();
        test_write32();
        test_stall();
        test_timeout();
        test_tie();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
